// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - decode-to-execute bundle between the ID stage and the ID/EX register
interface id_ex_reg_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
);
    // Decode-side fields.
    logic              ValidD;
    logic [XLEN-1:0]   RD1D;
    logic [XLEN-1:0]   RD2D;
    logic [XLEN-1:0]   ImmExtD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic              RegWriteD;
    logic [1:0]        ResultSrcD;
    logic              MemWriteD;
    logic              JumpD;
    logic              BranchD;
    logic [ALUC_W-1:0] ALUControlD;
    logic              ALUSrcD;

    // Execute-side registered copies.
    logic              ValidE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   ImmExtE;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic              RegWriteE;
    logic [1:0]        ResultSrcE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic [ALUC_W-1:0] ALUControlE;
    logic              ALUSrcE;

    modport master (
        output ValidD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
        input  ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
               RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE
    );

    modport slave (
        input  ValidD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
        output ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
               RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE
    );
endinterface

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall hold, flush bubble and valid tracking
module id_ex_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallE,
    input  logic        FlushE,
    id_ex_reg_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic [ALUC_W-1:0] alu_control;
        logic              alu_src;
        logic              valid;
    } ex_t;

    ex_t dec;
    ex_t ex_d;
    ex_t ex_q;

    always_comb begin
        dec             = '0;
        dec.rd1         = bus.RD1D;
        dec.rd2         = bus.RD2D;
        dec.imm         = bus.ImmExtD;
        dec.pc          = bus.PCD;
        dec.pc_plus4    = bus.PCPlus4D;
        dec.rs1         = bus.Rs1D;
        dec.rs2         = bus.Rs2D;
        dec.rd          = bus.RdD;
        dec.reg_write   = bus.RegWriteD;
        dec.result_src  = bus.ResultSrcD;
        dec.mem_write   = bus.MemWriteD;
        dec.jump        = bus.JumpD;
        dec.branch      = bus.BranchD;
        dec.alu_control = bus.ALUControlD;
        dec.alu_src     = bus.ALUSrcD;
        dec.valid       = bus.ValidD;
    end

    // An all-zero bubble is an ADD of zeros with every side-effect enable low;
    // flush outranks stall so a stalled real instruction can still be killed.
    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (!StallE) begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.RD1E        = ex_q.rd1;
    assign bus.RD2E        = ex_q.rd2;
    assign bus.ImmExtE     = ex_q.imm;
    assign bus.PCE         = ex_q.pc;
    assign bus.PCPlus4E    = ex_q.pc_plus4;
    assign bus.Rs1E        = ex_q.rs1;
    assign bus.Rs2E        = ex_q.rs2;
    assign bus.RdE         = ex_q.rd;
    assign bus.RegWriteE   = ex_q.reg_write;
    assign bus.ResultSrcE  = ex_q.result_src;
    assign bus.MemWriteE   = ex_q.mem_write;
    assign bus.JumpE       = ex_q.jump;
    assign bus.BranchE     = ex_q.branch;
    assign bus.ALUControlE = ex_q.alu_control;
    assign bus.ALUSrcE     = ex_q.alu_src;
    assign bus.ValidE      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - vector table plus randomized reference-model checks for id_ex_reg
module tb_id_ex_reg;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regw;
        logic [1:0]  rsrc;
        logic        memw;
        logic        jump;
        logic        branch;
        logic [2:0]  aluc;
        logic        alusrc;
        logic        valid;
    } bundle_t;

    typedef struct {
        logic    rst_n;
        logic    stall;
        logic    flush;
        bundle_t d;
        bundle_t exp;
        string   name;
    } vec_t;

    logic clk;
    logic rst_n;
    logic StallE;
    logic FlushE;
    int   checks;
    int   errors;
    vec_t vecs[$];

    id_ex_reg_if bus ();

    id_ex_reg dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .StallE (StallE),
        .FlushE (FlushE),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bundle_t b);
        bus.RD1D        = b.rd1;
        bus.RD2D        = b.rd2;
        bus.ImmExtD     = b.imm;
        bus.PCD         = b.pc;
        bus.PCPlus4D    = b.pc4;
        bus.Rs1D        = b.rs1;
        bus.Rs2D        = b.rs2;
        bus.RdD         = b.rd;
        bus.RegWriteD   = b.regw;
        bus.ResultSrcD  = b.rsrc;
        bus.MemWriteD   = b.memw;
        bus.JumpD       = b.jump;
        bus.BranchD     = b.branch;
        bus.ALUControlD = b.aluc;
        bus.ALUSrcD     = b.alusrc;
        bus.ValidD      = b.valid;
    endtask

    function automatic bundle_t sample();
        bundle_t b;
        b.rd1    = bus.RD1E;
        b.rd2    = bus.RD2E;
        b.imm    = bus.ImmExtE;
        b.pc     = bus.PCE;
        b.pc4    = bus.PCPlus4E;
        b.rs1    = bus.Rs1E;
        b.rs2    = bus.Rs2E;
        b.rd     = bus.RdE;
        b.regw   = bus.RegWriteE;
        b.rsrc   = bus.ResultSrcE;
        b.memw   = bus.MemWriteE;
        b.jump   = bus.JumpE;
        b.branch = bus.BranchE;
        b.aluc   = bus.ALUControlE;
        b.alusrc = bus.ALUSrcE;
        b.valid  = bus.ValidE;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        logic [191:0] raw;
        raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return bundle_t'(raw[$bits(bundle_t)-1:0]);
    endfunction

    task automatic check(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic s, input logic f,
                           input bundle_t d, input bundle_t e, input string n);
        vec_t v;
        v.rst_n = r;
        v.stall = s;
        v.flush = f;
        v.d     = d;
        v.exp   = e;
        v.name  = n;
        vecs.push_back(v);
    endtask

    initial begin
        bundle_t zb, ones, pt, dbf, one_v, fl, st, a5, oth, model, held, d;
        logic r, s, f;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;

        zb   = '0;
        ones = '1;
        pt = '0;
        pt.rd1 = 32'h0000_0005; pt.rd2 = 32'h0000_0003; pt.aluc = 3'b001;
        pt.regw = 1'b1; pt.rd = 5'd7; pt.valid = 1'b1;
        dbf = '0;
        dbf.rd1 = 32'hDEAD_BEEF; dbf.valid = 1'b1; dbf.regw = 1'b1; dbf.pc = 32'h0000_0100;
        one_v = dbf;
        one_v.rd1 = 32'h0000_0001;
        fl = ones;
        fl.aluc = 3'b101;
        st = '0;
        st.memw = 1'b1; st.valid = 1'b1; st.rd2 = 32'h1234_5678; st.imm = 32'hFFFF_FFF8;
        st.alusrc = 1'b1; st.rs1 = 5'd2; st.rs2 = 5'd9;
        a5 = '0;
        a5.rd2 = 32'hA5A5_A5A5; a5.valid = 1'b1; a5.rs2 = 5'd31;
        oth = ones;

        add_vec(1'b0, 1'b0, 1'b0, ones,  zb,    "reset_cycle1");
        add_vec(1'b0, 1'b0, 1'b0, ones,  zb,    "reset_cycle2");
        add_vec(1'b1, 1'b0, 1'b0, pt,    pt,    "pass_through");
        add_vec(1'b1, 1'b0, 1'b0, dbf,   dbf,   "load_deadbeef");
        add_vec(1'b1, 1'b1, 1'b0, one_v, dbf,   "stall_1");
        add_vec(1'b1, 1'b1, 1'b0, one_v, dbf,   "stall_2");
        add_vec(1'b1, 1'b1, 1'b0, one_v, dbf,   "stall_3");
        add_vec(1'b1, 1'b0, 1'b0, one_v, one_v, "stall_release");
        add_vec(1'b1, 1'b0, 1'b1, fl,    zb,    "flush_bubble");
        add_vec(1'b1, 1'b0, 1'b0, st,    st,    "load_store");
        add_vec(1'b1, 1'b1, 1'b1, st,    zb,    "stall_and_flush");
        add_vec(1'b1, 1'b0, 1'b0, a5,    a5,    "load_a5");
        add_vec(1'b1, 1'b1, 1'b0, oth,   a5,    "stall_hold_a5");
        add_vec(1'b0, 1'b1, 1'b0, oth,   zb,    "reset_during_stall");
        add_vec(1'b1, 1'b0, 1'b0, pt,    pt,    "reload_after_reset");
        add_vec(1'b0, 1'b0, 1'b1, ones,  zb,    "reset_during_flush");

        foreach (vecs[i]) begin
            rst_n  = vecs[i].rst_n;
            StallE = vecs[i].stall;
            FlushE = vecs[i].flush;
            drive(vecs[i].d);
            @(posedge clk);
            #1;
            check(vecs[i].name, sample(), vecs[i].exp);
        end

        // Outputs must not follow inputs between edges.
        rst_n  = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        drive(st);
        @(posedge clk);
        #1;
        held = sample();
        check("load_before_comb_probe", held, st);
        drive(ones);
        FlushE = 1'b1;
        #2;
        check("no_comb_path", sample(), st);
        FlushE = 1'b0;

        model = st;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 19) != 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            d = rand_bundle();
            rst_n  = r;
            StallE = s;
            FlushE = f;
            drive(d);
            @(posedge clk);
            #1;
            if (!r || f) begin
                model = '0;
            end else if (!s) begin
                model = d;
            end
            check($sformatf("random_%0d", n), sample(), model);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
